tempo_step_sequencer: RTL

Beat-driven step sequencer that sits between the TempoGenerator AXI4-Lite peripheral and the synth voice engine. On each beat tick it fetches one entry from an internal step table and issues note-off/note-on events to the voice through a valid/ready handshake. The step table and run controls are driven from the same register block that configures the tempo. The sequencer counts beat ticks it cannot service in time.

---
 rtl/tempo_step_sequencer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tempo_step_sequencer.sv
// Beat-driven step sequencer: on each tempo tick it fetches one step-table entry
// and issues note-off / note-on events to the voice engine over valid/ready.
module tempo_step_sequencer #(
  parameter int  STEPS  = 16,
  parameter int  NOTE_W = 7,
  parameter int  VEL_W  = 7,
  parameter int  OVR_W  = 8,
  localparam int SW     = $clog2(STEPS),
  localparam int EW     = 1 + NOTE_W + VEL_W
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              tick_in,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [SW-1:0]     last_step,
  input  logic              wr_en,
  input  logic [SW-1:0]     wr_addr,
  input  logic [EW-1:0]     wr_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              ev_on,
  output logic [NOTE_W-1:0] ev_note,
  output logic [VEL_W-1:0]  ev_vel,
  output logic              running,
  output logic [SW-1:0]     cur_step,
  output logic [OVR_W-1:0]  overrun_cnt
);

  // state | meaning
  // IDLE  | not sequencing; ticks ignored
  // WAIT  | waiting for a tick or a pending tick
  // FETCH | read entry[ptr], advance pointer
  // OFF   | presenting note-off for the sounding note
  // ON    | presenting note-on for the fetched entry
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FETCH, S_OFF, S_ON} state_t;

  state_t              state_q;
  logic [EW-1:0]       table_q [STEPS];
  logic [SW-1:0]       ptr_q, last_q, cur_step_q;
  logic                sounding_q;
  logic [NOTE_W-1:0]   snd_note_q;
  logic                pending_q, done_q, end_q, abort_q;
  logic                gate_q;
  logic [NOTE_W-1:0]   note_q;
  logic [VEL_W-1:0]    vel_q;
  logic                ev_valid_q, ev_on_q;
  logic [NOTE_W-1:0]   ev_note_q;
  logic [VEL_W-1:0]    ev_vel_q;
  logic [OVR_W-1:0]    ovr_q;

  logic [EW-1:0]       fetch_d;
  logic                fetch_gate_d;
  logic [NOTE_W-1:0]   fetch_note_d;
  logic [VEL_W-1:0]    fetch_vel_d;
  logic                wrap_d, accept_d, abort_d, trig_d;

  assign fetch_d      = table_q[ptr_q];
  assign fetch_gate_d = fetch_d[EW-1];
  assign fetch_note_d = fetch_d[EW-2:VEL_W];
  assign fetch_vel_d  = fetch_d[VEL_W-1:0];
  assign wrap_d       = (ptr_q == last_q);
  assign accept_d     = ev_valid_q & ev_ready;
  // A stop seen while an event is stalled is remembered until the handshake ends.
  assign abort_d      = stop | abort_q;
  assign trig_d       = tick_in | pending_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < STEPS; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      last_q     <= '0;
      cur_step_q <= '0;
      sounding_q <= 1'b0;
      snd_note_q <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      end_q      <= 1'b0;
      abort_q    <= 1'b0;
      gate_q     <= 1'b0;
      note_q     <= '0;
      vel_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_on_q    <= 1'b0;
      ev_note_q  <= '0;
      ev_vel_q   <= '0;
      ovr_q      <= '0;
    end else begin
      // Ticks arriving outside WAIT: first is held as pending, further ones are dropped.
      if (tick_in && state_q != S_IDLE && state_q != S_WAIT) begin
        if (!pending_q) pending_q <= 1'b1;
        else if (ovr_q != '1) ovr_q <= ovr_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (start && !stop) begin
            state_q    <= S_WAIT;
            ptr_q      <= '0;
            last_q     <= last_step;
            cur_step_q <= '0;
            pending_q  <= 1'b0;
            done_q     <= 1'b0;
            end_q      <= 1'b0;
            ovr_q      <= '0;
          end
        end

        S_WAIT: begin
          if (abort_d || (trig_d && done_q)) begin
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            if (sounding_q) begin
              state_q    <= S_OFF;
              end_q      <= 1'b1;
              ev_valid_q <= 1'b1;
              ev_on_q    <= 1'b0;
              ev_note_q  <= snd_note_q;
              ev_vel_q   <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (trig_d) begin
            pending_q <= 1'b0;
            state_q   <= S_FETCH;
          end
        end

        S_FETCH: begin
          gate_q     <= fetch_gate_d;
          note_q     <= fetch_note_d;
          vel_q      <= fetch_vel_d;
          cur_step_q <= ptr_q;
          ptr_q      <= wrap_d ? '0 : ptr_q + 1'b1;
          if (abort_d) begin
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            if (sounding_q) begin
              state_q    <= S_OFF;
              end_q      <= 1'b1;
              ev_valid_q <= 1'b1;
              ev_on_q    <= 1'b0;
              ev_note_q  <= snd_note_q;
              ev_vel_q   <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            if (wrap_d && !loop) done_q <= 1'b1;
            if (sounding_q) begin
              state_q    <= S_OFF;
              end_q      <= 1'b0;
              ev_valid_q <= 1'b1;
              ev_on_q    <= 1'b0;
              ev_note_q  <= snd_note_q;
              ev_vel_q   <= '0;
            end else if (fetch_gate_d) begin
              state_q    <= S_ON;
              ev_valid_q <= 1'b1;
              ev_on_q    <= 1'b1;
              ev_note_q  <= fetch_note_d;
              ev_vel_q   <= fetch_vel_d;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end

        S_OFF: begin
          if (accept_d) begin
            sounding_q <= 1'b0;
            if (end_q || abort_d) begin
              state_q    <= S_IDLE;
              ev_valid_q <= 1'b0;
              pending_q  <= 1'b0;
              done_q     <= 1'b0;
              end_q      <= 1'b0;
              abort_q    <= 1'b0;
            end else if (gate_q) begin
              state_q   <= S_ON;
              ev_on_q   <= 1'b1;
              ev_note_q <= note_q;
              ev_vel_q  <= vel_q;
            end else begin
              state_q    <= S_WAIT;
              ev_valid_q <= 1'b0;
            end
          end else begin
            abort_q <= abort_d;
          end
        end

        S_ON: begin
          if (accept_d) begin
            sounding_q <= 1'b1;
            snd_note_q <= ev_note_q;
            if (abort_d) begin
              // Aborted mid note-on: release the note just started, then stop.
              pending_q <= 1'b0;
              done_q    <= 1'b0;
              abort_q   <= 1'b0;
              state_q   <= S_OFF;
              end_q     <= 1'b1;
              ev_on_q   <= 1'b0;
              ev_vel_q  <= '0;
            end else begin
              state_q    <= S_WAIT;
              ev_valid_q <= 1'b0;
            end
          end else begin
            abort_q <= abort_d;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ev_valid    = ev_valid_q;
  assign ev_on       = ev_on_q;
  assign ev_note     = ev_note_q;
  assign ev_vel      = ev_vel_q;
  assign running     = (state_q != S_IDLE);
  assign cur_step    = cur_step_q;
  assign overrun_cnt = ovr_q;

endmodule
